alu_decode_stage: RTL and testbench
===================================

// Module: alu_decode_stage
// PURPOSE
//  Registered decode stage that produces ALU operations. Consumes 32-bit RV32I OP and OP-IMM
//  instructions plus register-file read data over a valid/ready handshake. Emits the ALU
//  function (ALU_FNS::ALU_FN_t), funct7, and the a/b operands and rd toward the EX stage.
//  Sits between fetch/regfile read and `alu`. A 2-entry skid buffer fully registers both
//  handshake directions.
// PARAMETERS
//  WIDTH  32  datapath width of a, b, rs1_data, rs2_data (>= 5)
// PORTS
//  clk          in   1      sole clock, rising edge
//  rst_n        in   1      synchronous active-low reset
//  instr_valid  in   1      upstream has an instruction
//  instr_ready  out  1      stage can accept; registered, no comb path from ex_ready
//  instr        in   32     RV32I instruction word
//  rs1_data     in   WIDTH  rs1 value, sampled with instr
//  rs2_data     in   WIDTH  rs2 value, sampled with instr
//  ex_valid     out  1      decoded op valid
//  ex_ready     in   1      EX stage accepts
//  fn           out  3      ALU_FN_t (encoding == funct3)
//  funct7       out  7      [31:25] forwarded to alu (0x20 = SUB/SRA, else 0)
//  a            out  WIDTH  ALU operand a (= rs1_data)
//  b            out  WIDTH  ALU operand b (rs2_data or immediate)
//  rd           out  5      destination register
//  illegal      out  1      decoded word is not a legal OP/OP-IMM
// BEHAVIOUR
//  Reset (rst_n=0 at edge): ex_valid=0, instr_ready=1, fn=ADD_SUB, funct7=0, a=b=0, rd=0,
//   illegal=0. Both buffer entries are invalidated. Reset mid-stall discards all held ops.
//  Handshake: transfer when valid&&ready at a rising edge. Accept in cycle N gives ex_valid
//   in cycle N+1 when the buffer is empty. ex_valid/outputs hold stable until ex_ready.
//  Skid buffer: entries MAIN (drives outputs) and SKID. Occupancy states:
//   EMPTY  -> accept: MAIN.
//   ONE    -> accept & ex_ready: MAIN replaced; accept & !ex_ready: SKID filled, instr_ready<=0.
//          -> !accept & ex_ready: EMPTY.
//   FULL   -> ex_ready: SKID moves to MAIN, instr_ready<=1; else hold.
//   Strict FIFO order; no loss, no duplication.
//  Decode (opcode=instr[6:0], funct3=instr[14:12], rd=instr[11:7]; fn=funct3 always):
//   OP 0110011: b=rs2_data; funct7=instr[31:25]. Legal iff funct7==0, or funct7==0x20 with
//    funct3 in {000,101}.
//   OP-IMM 0010011, funct3 != 001/101: b=sext(instr[31:20]) truncated to WIDTH; funct7=0
//    (ADDI never subtracts).
//   OP-IMM SLLI/SRLI/SRAI: b=zext(instr[24:20]); funct7=instr[31:25]. Legal iff funct7==0, or
//    funct7==0x20 with funct3=101.
//   Other opcodes: illegal.
//  Illegal words: fn=ADD_SUB, funct7=0, a=b=0, rd=0, illegal=1. Handling depends on macro.
//  Simultaneous accept and drain in FULL is impossible because instr_ready=0.
// CONFIGURATION
//  ALU_DECODE_DROP_ILLEGAL_EN defined:
//   - illegal words are accepted and never enter the buffer; ex_valid is not raised.
//   - illegal pulses 1 for the one cycle after acceptance, independent of ex_valid.
//  Undefined:
//   - illegal words flow through the buffer like normal ops, with illegal=1 qualified by
//     ex_valid.
// TESTING
//  1 Reset: after rst_n=0 for 2 cycles -> ex_valid=0, instr_ready=1, illegal=0.
//  2 add x3,x1,x2 0x002081B3, rs1=05, rs2=06, WIDTH=8, ex_ready=1 -> next cycle ex_valid=1,
//    fn=ADD_SUB, funct7=00, a=05, b=06, rd=3; alu out=0B.
//  3 sub 0x402081B3 -> funct7=20, alu out=FF. addi x1,x0,-5 0xFFB00093 -> b=FB, funct7=00.
//  4 srai x5,x6,3 0x40335293, rs1=F0 -> fn=SRL_SRA, funct7=20, b=03, rd=5.
//  5 Backpressure: ex_ready=0, send A,B,C -> instr_ready=0 after B; C held upstream.
//    ex_ready=1 -> A,B,C in order, one per cycle.
//  6 Illegal 0x0000007F -> without macro: ex_valid=1, illegal=1, a=b=0. With macro: no
//    ex_valid, 1-cycle illegal pulse. Reset mid-FULL -> buffer empty next cycle.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I OP/OP-IMM decode stage feeding the ALU, fully registered through a 2-entry skid buffer.
// Optional build macro: ALU_DECODE_DROP_ILLEGAL_EN (drop illegal words, pulse `illegal` instead).
module alu_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [2:0]       fn,
  output logic [6:0]       funct7,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [4:0]       rd,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] FN_ADD_SUB = 3'b000;
  localparam logic [2:0] FN_SLL     = 3'b001;
  localparam logic [2:0] FN_SRL_SRA = 3'b101;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [2:0]       fn;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd;
    logic             illegal;
  } op_t;

  localparam op_t OP_ZERO = {$bits(op_t){1'b0}};

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_t;

  occ_t occ_r, occ_nxt_s;
  op_t  main_r, main_nxt_s;
  op_t  skid_r, skid_nxt_s;
  op_t  dec_s;
  logic ready_r, ready_nxt_s;
  logic valid_r, valid_nxt_s;
  logic illegal_r, illegal_nxt_s;
  logic accept_s, push_s, drain_s;
  logic unused_rs_fields_s;

  // Illegal words collapse to an all-zero op with only the illegal flag set.
  function automatic op_t decode_op(input logic [31:0] w,
                                    input logic [WIDTH-1:0] r1,
                                    input logic [WIDTH-1:0] r2);
    op_t  o;
    logic legal;
    o         = OP_ZERO;
    o.fn      = w[14:12];
    o.rd      = w[11:7];
    o.a       = r1;
    legal     = 1'b0;
    case (w[6:0])
      OPC_OP: begin
        o.b      = r2;
        o.funct7 = w[31:25];
        legal    = (w[31:25] == F7_ZERO) ||
                   ((w[31:25] == F7_ALT) &&
                    ((w[14:12] == FN_ADD_SUB) || (w[14:12] == FN_SRL_SRA)));
      end
      OPC_OP_IMM: begin
        if ((w[14:12] == FN_SLL) || (w[14:12] == FN_SRL_SRA)) begin
          o.b      = WIDTH'(w[24:20]);
          o.funct7 = w[31:25];
          legal    = (w[31:25] == F7_ZERO) ||
                     ((w[31:25] == F7_ALT) && (w[14:12] == FN_SRL_SRA));
        end else begin
          o.b      = WIDTH'($signed(w[31:20]));
          o.funct7 = F7_ZERO;
          legal    = 1'b1;
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (!legal) begin
      o         = OP_ZERO;
      o.illegal = 1'b1;
    end else begin
      o.illegal = 1'b0;
    end
    return o;
  endfunction

  assign dec_s    = decode_op(instr, rs1_data, rs2_data);
  assign accept_s = instr_valid & ready_r;
  assign drain_s  = valid_r & ex_ready;
  // Register-source fields are consumed upstream by the register file, not here.
  assign unused_rs_fields_s = ^instr[19:15];

`ifdef ALU_DECODE_DROP_ILLEGAL_EN
  assign push_s        = accept_s & ~dec_s.illegal;
  assign illegal_nxt_s = accept_s & dec_s.illegal;
`else
  assign push_s        = accept_s;
  assign illegal_nxt_s = (occ_nxt_s != OCC_EMPTY) & main_nxt_s.illegal;
`endif

  // Next buffer occupancy and entry contents.
  always_comb begin
    occ_nxt_s  = occ_r;
    main_nxt_s = main_r;
    skid_nxt_s = skid_r;
    case (occ_r)
      OCC_EMPTY: begin
        if (push_s) begin
          main_nxt_s = dec_s;
          occ_nxt_s  = OCC_ONE;
        end else begin
          occ_nxt_s  = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push_s && drain_s) begin
          main_nxt_s = dec_s;
          occ_nxt_s  = OCC_ONE;
        end else if (push_s) begin
          skid_nxt_s = dec_s;
          occ_nxt_s  = OCC_FULL;
        end else if (drain_s) begin
          occ_nxt_s  = OCC_EMPTY;
        end else begin
          occ_nxt_s  = OCC_ONE;
        end
      end
      OCC_FULL: begin
        // instr_ready is low here, so only a drain can happen.
        if (drain_s) begin
          main_nxt_s = skid_r;
          occ_nxt_s  = OCC_ONE;
        end else begin
          occ_nxt_s  = OCC_FULL;
        end
      end
      default: begin
        occ_nxt_s = OCC_EMPTY;
      end
    endcase
    ready_nxt_s = (occ_nxt_s != OCC_FULL);
    valid_nxt_s = (occ_nxt_s != OCC_EMPTY);
  end

  // State, buffer entries and registered handshake/flag outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r     <= OCC_EMPTY;
      main_r    <= OP_ZERO;
      skid_r    <= OP_ZERO;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      occ_r     <= occ_nxt_s;
      main_r    <= main_nxt_s;
      skid_r    <= skid_nxt_s;
      ready_r   <= ready_nxt_s;
      valid_r   <= valid_nxt_s;
      illegal_r <= illegal_nxt_s;
    end
  end

  assign instr_ready = ready_r;
  assign ex_valid    = valid_r;
  assign fn          = main_r.fn;
  assign funct7      = main_r.funct7;
  assign a           = main_r.a;
  assign b           = main_r.b;
  assign rd          = main_r.rd;
  assign illegal     = illegal_r;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed cases plus randomized traffic
// checked against a queue-based occupancy/decode reference model.
module tb_alu_decode_stage;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic         ex_valid;
  logic         ex_ready;
  logic [2:0]   fn;
  logic [6:0]   funct7;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   rd;
  logic         illegal;

  alu_decode_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .fn(fn), .funct7(funct7), .a(a), .b(b), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   fn;
    logic [6:0]   f7;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
    logic         ill;
  } exp_t;

  exp_t q[$];
  int   drained_rd[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  logic pulse_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_decode(input logic [31:0] w, input logic [W-1:0] r1,
                                        input logic [W-1:0] r2);
    exp_t e;
    int opc, f3, f7, imm;
    bit ok;
    opc = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    e.fn = w[14:12]; e.rd = w[11:7]; e.a = r1; e.b = '0; e.f7 = '0; e.ill = 1'b0; ok = 0;
    if (opc == 'h33) begin
      ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      e.b = r2; e.f7 = w[31:25];
    end else if (opc == 'h13 && (f3 == 1 || f3 == 5)) begin
      ok = (f7 == 0) || (f7 == 32 && f3 == 5);
      e.b = W'(w[24:20]); e.f7 = w[31:25];
    end else if (opc == 'h13) begin
      imm = int'(w[31:20]);
      if (imm >= 2048) imm -= 4096;
      e.b = W'(imm);
      ok = 1;
    end
    if (!ok) begin
      e.fn = '0; e.f7 = '0; e.a = '0; e.b = '0; e.rd = '0; e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] alu_ref(input logic [2:0] f, input logic [6:0] f7,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    case (f)
      3'd0: return f7[5] ? x - y : x + y;
      3'd1: return x << y[2:0];
      3'd2: return W'($signed(x) < $signed(y));
      3'd3: return W'(x < y);
      3'd4: return x ^ y;
      3'd5: return f7[5] ? W'($signed(x) >>> y[2:0]) : x >> y[2:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3,
                                       input logic [4:0] d, input logic [6:0] opc);
    return {f7, r2, r1, f3, d, opc};
  endfunction

  // One clock: compare against the model at the falling edge, advance the model, move past the rising edge.
  task automatic step();
    exp_t e;
    logic acc, drn;
    @(negedge clk);
    if (rst_n) begin
      check_eq("ex_valid", ex_valid, q.size() != 0);
      check_eq("instr_ready", instr_ready, q.size() < 2);
`ifdef ALU_DECODE_DROP_ILLEGAL_EN
      check_eq("illegal_pulse", illegal, pulse_exp);
`endif
      if (q.size() != 0) begin
        check_eq("fn", fn, q[0].fn);
        check_eq("funct7", funct7, q[0].f7);
        check_eq("a", a, q[0].a);
        check_eq("b", b, q[0].b);
        check_eq("rd", rd, q[0].rd);
`ifndef ALU_DECODE_DROP_ILLEGAL_EN
        check_eq("illegal", illegal, q[0].ill);
`endif
      end
      acc = instr_valid && (q.size() < 2);
      drn = ex_ready && (q.size() != 0);
      e = model_decode(instr, rs1_data, rs2_data);
      if (drn) begin
        drained_rd.push_back(int'(rd));
        void'(q.pop_front());
      end
`ifdef ALU_DECODE_DROP_ILLEGAL_EN
      if (acc && !e.ill) q.push_back(e);
`else
      if (acc) q.push_back(e);
`endif
      pulse_exp = acc && e.ill;
    end else begin
      q.delete();
      pulse_exp = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    int r;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0; rs1_data = '0; rs2_data = '0;
    ex_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_eq("rst_ex_valid", ex_valid, 0);
    check_eq("rst_instr_ready", instr_ready, 1);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_fn", fn, 0);
    check_eq("rst_funct7", funct7, 0);
    check_eq("rst_a", a, 0);
    check_eq("rst_b", b, 0);
    check_eq("rst_rd", rd, 0);

    // add x3,x1,x2
    ex_ready = 1'b1; instr_valid = 1'b1; instr = 32'h002081B3; rs1_data = 8'h05; rs2_data = 8'h06;
    step();
    instr_valid = 1'b0;
    check_eq("add_valid", ex_valid, 1);
    check_eq("add_fn", fn, 0);
    check_eq("add_funct7", funct7, 7'h00);
    check_eq("add_a", a, 8'h05);
    check_eq("add_b", b, 8'h06);
    check_eq("add_rd", rd, 3);
    check_eq("add_alu", alu_ref(fn, funct7, a, b), 8'h0B);
    step();

    // sub x3,x1,x2
    instr_valid = 1'b1; instr = 32'h402081B3;
    step();
    instr_valid = 1'b0;
    check_eq("sub_funct7", funct7, 7'h20);
    check_eq("sub_alu", alu_ref(fn, funct7, a, b), 8'hFF);
    step();

    // addi x1,x0,-5
    instr_valid = 1'b1; instr = 32'hFFB00093; rs1_data = 8'h00;
    step();
    instr_valid = 1'b0;
    check_eq("addi_b", b, 8'hFB);
    check_eq("addi_funct7", funct7, 7'h00);
    check_eq("addi_rd", rd, 1);
    step();

    // srai x5,x6,3
    instr_valid = 1'b1; instr = 32'h40335293; rs1_data = 8'hF0;
    step();
    instr_valid = 1'b0;
    check_eq("srai_fn", fn, 3'b101);
    check_eq("srai_funct7", funct7, 7'h20);
    check_eq("srai_b", b, 8'h03);
    check_eq("srai_rd", rd, 5);
    check_eq("srai_alu", alu_ref(fn, funct7, a, b), 8'hFE);
    step();

    // Backpressure: A, B fill the buffer, C waits upstream.
    drained_rd.delete();
    ex_ready = 1'b0; instr_valid = 1'b1;
    instr = mk_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1, 7'h33); step();
    instr = mk_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd2, 7'h33); step();
    instr = mk_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33);
    check_eq("bp_ready_low", instr_ready, 0);
    step();
    check_eq("bp_ready_hold", instr_ready, 0);
    check_eq("bp_valid_hold", ex_valid, 1);
    ex_ready = 1'b1;
    step();
    check_eq("bp_ready_back", instr_ready, 1);
    step();
    instr_valid = 1'b0;
    step(); step();
    check_eq("bp_drain_count", drained_rd.size(), 3);
    for (int i = 0; i < 3; i++)
      check_eq("bp_order", (i < drained_rd.size()) ? drained_rd[i] : -1, i + 1);

    // Illegal word
    ex_ready = 1'b0; instr_valid = 1'b1; instr = 32'h0000007F; rs1_data = 8'hAA; rs2_data = 8'h55;
    step();
    instr_valid = 1'b0;
`ifdef ALU_DECODE_DROP_ILLEGAL_EN
    check_eq("ill_no_valid", ex_valid, 0);
    check_eq("ill_pulse", illegal, 1);
    step();
    check_eq("ill_pulse_end", illegal, 0);
`else
    check_eq("ill_valid", ex_valid, 1);
    check_eq("ill_flag", illegal, 1);
    check_eq("ill_a", a, 0);
    check_eq("ill_b", b, 0);
    ex_ready = 1'b1;
    step();
`endif

    // Reset while full
    ex_ready = 1'b0; instr_valid = 1'b1;
    instr = mk_r(7'h00, 5'd4, 5'd3, 3'd6, 5'd7, 7'h33); step();
    instr = mk_r(7'h00, 5'd4, 5'd3, 3'd7, 5'd8, 7'h33); step();
    check_eq("full_ready_low", instr_ready, 0);
    rst_n = 1'b0; instr_valid = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("midrst_valid", ex_valid, 0);
    check_eq("midrst_ready", instr_ready, 1);
    step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      w[6:0] = (r < 4) ? 7'h33 : (r < 8) ? 7'h13 : w[6:0];
      r = $urandom_range(0, 3);
      if (r == 0) w[31:25] = 7'h00;
      else if (r == 1) w[31:25] = 7'h20;
      instr = w;
      instr_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      rs1_data = W'($urandom);
      rs2_data = W'($urandom);
      step();
    end
    instr_valid = 1'b0; ex_ready = 1'b1;
    repeat (4) step();
    check_eq("final_empty", ex_valid, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
